// File: rtl/gb_apu_pkg.sv
// Shared frame-sequencer constants, step type and strobe decode for the APU blocks.
package gb_apu_pkg;

    localparam int FS_STEPS        = 8;
    localparam int FS_SWEEP_STEP_A = 2;
    localparam int FS_SWEEP_STEP_B = 6;
    localparam int FS_ENV_STEP     = 7;

    typedef logic [2:0] fs_step_t;

    typedef struct packed {
        logic length;
        logic sweep;
        logic vol_env;
    } fs_strobe_t;

    // Strobes produced when the given step executes.
    function automatic fs_strobe_t fs_decode(input fs_step_t s);
        fs_strobe_t d;
        d.length  = ~s[0];
        d.sweep   = (s == fs_step_t'(FS_SWEEP_STEP_A)) || (s == fs_step_t'(FS_SWEEP_STEP_B));
        d.vol_env = (s == fs_step_t'(FS_ENV_STEP));
        return d;
    endfunction

endpackage

// File: rtl/gb_apu_frame_tick_gen.sv
// 512 Hz step-event source: DIV falling-edge detect or internal prescaler,
// plus suppression of the first event after a power-on with the DIV bit high.
module gb_apu_frame_tick_gen #(
    parameter bit USE_INTERNAL_TIMER = 1'b0,
    parameter int CLK_DIVIDER        = 8192
) (
    input  logic clk,
    input  logic reset,
    input  logic apu_enable,
    input  logic div_bit,
    output logic ev
);

    localparam int PW = (CLK_DIVIDER > 1) ? $clog2(CLK_DIVIDER) : 1;

    logic          div_q;
    logic          en_q;
    logic          skip_first;
    logic [PW-1:0] prescaler;
    logic          ev_div;
    logic          ev_tmr;
    logic          raw_ev;

    assign ev_div = div_q & ~div_bit;
    assign ev_tmr = (prescaler == PW'(CLK_DIVIDER - 1));
    assign raw_ev = USE_INTERNAL_TIMER ? ev_tmr : ev_div;
    assign ev     = raw_ev & ~skip_first;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= 1'b0;
            en_q  <= 1'b1;
        end else begin
            div_q <= div_bit;
            en_q  <= apu_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !apu_enable || ev_tmr)
            prescaler <= '0;
        else
            prescaler <= prescaler + 1'b1;
    end

    // en_q resets high so leaving reset with the APU already on is not a power-on.
    always_ff @(posedge clk) begin
        if (reset || !apu_enable || USE_INTERNAL_TIMER)
            skip_first <= 1'b0;
        else if (!en_q && div_bit)
            skip_first <= 1'b1;
        else if (raw_ev)
            skip_first <= 1'b0;
    end

endmodule

// File: rtl/gb_apu_frame_sequencer.sv
// APU frame sequencer: 8-step counter emitting 1-cycle length, sweep and
// envelope strobes on each 512 Hz step event.
module gb_apu_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter bit USE_INTERNAL_TIMER = 1'b0,
    parameter int CLK_DIVIDER        = 8192
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_enable,
    input  logic       div_bit,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_vol_env,
    output logic [2:0] step
);

    logic       ev;
    fs_strobe_t nxt;

    gb_apu_frame_tick_gen #(
        .USE_INTERNAL_TIMER (USE_INTERNAL_TIMER),
        .CLK_DIVIDER        (CLK_DIVIDER)
    ) u_tick (
        .clk        (clk),
        .reset      (reset),
        .apu_enable (apu_enable),
        .div_bit    (div_bit),
        .ev         (ev)
    );

    assign nxt = fs_decode(fs_step_t'(step));

    // Power-off wins over a coincident event; step wraps naturally at 3 bits.
    always_ff @(posedge clk) begin
        if (reset || !apu_enable) begin
            step           <= '0;
            clk_length_ctr <= 1'b0;
            clk_sweep      <= 1'b0;
            clk_vol_env    <= 1'b0;
        end else if (ev) begin
            step           <= step + 3'd1;
            clk_length_ctr <= nxt.length;
            clk_sweep      <= nxt.sweep;
            clk_vol_env    <= nxt.vol_env;
        end else begin
            clk_length_ctr <= 1'b0;
            clk_sweep      <= 1'b0;
            clk_vol_env    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gb_apu_frame_sequencer.sv
// Scoreboard bench for the frame sequencer in DIV-edge and internal-timer modes.
module tb_gb_apu_frame_sequencer;
    import gb_apu_pkg::*;

    typedef struct {
        int       cyc;
        bit       len;
        bit       sw;
        bit       env;
        bit [2:0] stp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1, apu_enable = 1'b0, div_bit = 1'b0;
    logic       en2 = 1'b0, div2 = 1'b0;
    logic       len1, sw1, env1, len2, sw2, env2;
    logic [2:0] step1, step2;

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   n_len = 0, n_sw = 0, n_env = 0;
    exp_t q[$];
    exp_t q2[$];

    // reference model state
    int m_step = 0;
    bit m_skip = 1'b0, m_div_q = 1'b0, m_en_q = 1'b1;

    gb_apu_frame_sequencer dut (
        .clk(clk), .reset(reset), .apu_enable(apu_enable), .div_bit(div_bit),
        .clk_length_ctr(len1), .clk_sweep(sw1), .clk_vol_env(env1), .step(step1)
    );

    gb_apu_frame_sequencer #(.USE_INTERNAL_TIMER(1'b1), .CLK_DIVIDER(4)) dut_tmr (
        .clk(clk), .reset(reset), .apu_enable(en2), .div_bit(div2),
        .clk_length_ctr(len2), .clk_sweep(sw2), .clk_vol_env(env2), .step(step2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Strobes for step s: even steps clock length, steps 2 and 6 sweep, last step envelope.
    function automatic exp_t mk(input int c, input int s);
        exp_t e;
        e.cyc = c;
        e.len = (s % 2 == 0);
        e.sw  = (s % 4 == 2);
        e.env = (s == FS_STEPS - 1);
        e.stp = 3'((s + 1) % FS_STEPS);
        return e;
    endfunction

    // Model of one sampling posedge with the given inputs.
    task automatic model(input bit r, input bit en, input bit d);
        bit evt;
        evt = m_div_q && !d;
        if (r) begin
            m_step = 0; m_skip = 0; m_div_q = 0; m_en_q = 1;
            return;
        end
        if (!en) begin
            m_step = 0; m_skip = 0;
        end else if (!m_en_q && d) begin
            m_skip = 1;
        end else if (evt) begin
            if (m_skip) m_skip = 0;
            else begin
                q.push_back(mk(cyc + 1, m_step));
                m_step = (m_step + 1) % FS_STEPS;
            end
        end
        m_div_q = d;
        m_en_q  = en;
    endtask

    task automatic drive(input bit r, input bit en, input bit d);
        reset = r; apu_enable = en; div_bit = d;
        model(r, en, d);
        @(posedge clk); #1;
        chk("step", int'(step1), m_step);
    endtask

    task automatic edge_ev(input int hi, input int lo);
        repeat (hi) drive(0, 1, 1);
        repeat (lo) drive(0, 1, 0);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (len1 | sw1 | env1) begin
            n_len += int'(len1); n_sw += int'(sw1); n_env += int'(env1);
            if (q.size() == 0) chk("unexpected_strobe", int'({len1, sw1, env1}), 0);
            else begin
                e = q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("strobes", int'({len1, sw1, env1}), int'({e.len, e.sw, e.env}));
                chk("step_after", int'(step1), int'(e.stp));
            end
        end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("missed_strobe", int'({len1, sw1, env1}), int'({e.len, e.sw, e.env}));
        end
    end

    always @(negedge clk) begin : mon2
        exp_t e;
        if (len2 | sw2 | env2) begin
            if (q2.size() == 0) chk("tmr_unexpected_strobe", int'({len2, sw2, env2}), 0);
            else begin
                e = q2.pop_front();
                chk("tmr_strobe_cycle", cyc, e.cyc);
                chk("tmr_strobes", int'({len2, sw2, env2}), int'({e.len, e.sw, e.env}));
                chk("tmr_step_after", int'(step2), int'(e.stp));
            end
        end else if (q2.size() != 0 && q2[0].cyc <= cyc) begin
            e = q2.pop_front();
            chk("tmr_missed_strobe", int'({len2, sw2, env2}), int'({e.len, e.sw, e.env}));
        end
    end

    initial begin
        int l0, s0, v0, base;
        bit en, d;

        // 1: reset then idle with div low
        drive(1, 1, 0);
        drive(1, 1, 0);
        chk("reset_strobes", int'({len1, sw1, env1}), 0);
        chk("reset_step", int'(step1), 0);
        repeat (20) drive(0, 1, 0);

        // 2: 16 edges, 32 clk apart
        l0 = n_len; s0 = n_sw; v0 = n_env;
        repeat (16) edge_ev(16, 16);
        chk("len_count", n_len - l0, 8);
        chk("sweep_count", n_sw - s0, 4);
        chk("env_count", n_env - v0, 2);
        chk("wrap_step", int'(step1), 0);

        // 3: power-on with div high swallows the first edge
        repeat (3) drive(0, 0, 1);
        repeat (3) drive(0, 1, 1);
        l0 = n_len;
        repeat (4) drive(0, 1, 0);
        chk("skip_no_strobe", n_len - l0, 0);
        chk("skip_step", int'(step1), 0);
        edge_ev(2, 3);
        chk("post_skip_step", int'(step1), 1);

        // 4: power-off coincident with edge at step 5
        repeat (4) edge_ev(2, 3);
        chk("at_step5", int'(step1), 5);
        drive(0, 1, 1);
        drive(0, 0, 0);
        chk("poweroff_step", int'(step1), 0);
        repeat (2) drive(0, 0, 0);
        repeat (2) drive(0, 1, 0);
        edge_ev(2, 3);
        chk("reenable_step", int'(step1), 1);

        // 5: reset coincident with step-7 edge
        repeat (6) edge_ev(2, 3);
        chk("at_step7", int'(step1), 7);
        drive(0, 1, 1);
        drive(1, 1, 0);
        chk("reset_hit_step", int'(step1), 0);
        repeat (3) drive(0, 1, 0);
        edge_ev(2, 3);
        chk("post_reset_step", int'(step1), 1);

        // random inputs, including back-to-back toggles, power cycling and resets
        en = 1'b1; d = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 40) == 0) en = !en;
            if ($urandom_range(0, 2) != 0) d = ($urandom_range(0, 1) == 1);
            drive($urandom_range(0, 150) == 0, en, d);
        end
        repeat (4) drive(0, 1, 0);

        // 6: internal timer, divider 4, div_bit noise ignored
        base = cyc;
        for (int k = 0; k < 40; k++) q2.push_back(mk(base + 4 + 4 * k, k % FS_STEPS));
        en2 = 1'b1;
        for (int i = 0; i < 162; i++) begin
            div2 = ($urandom_range(0, 1) == 1);
            drive(0, 1, 0);
        end
        en2 = 1'b0;
        repeat (6) drive(0, 1, 0);
        chk("tmr_off_step", int'(step2), 0);

        chk("queue_drained", q.size(), 0);
        chk("tmr_queue_drained", q2.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
